fetch_aligner: RTL and testbench
================================

FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of first instruction after reset; bit 0 ignored.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  redirect request, sampled on rising edge.
REQ-005 flush_pc  input  32  redirect target; bit 0 ignored.
REQ-006 in_valid  input  1  upstream memory word valid.
REQ-007 in_ready  output  1  aligner accepts in_data this cycle.
REQ-008 in_data  input  32  word fetched from fetch_addr; little-endian halfwords.
REQ-009 fetch_addr  output  32  word-aligned address of next word to accept.
REQ-010 out_valid  output  1  out_instr/out_pc/out_is_c valid.
REQ-011 out_ready  input  1  downstream (decompressor + instruction-select mux) consumes.
REQ-012 out_instr  output  32  aligned instruction; upper 16 bits zero when compressed.
REQ-013 out_pc  output  32  address of out_instr.
REQ-014 out_is_c  output  1  1 = 16-bit compressed instruction; drives the downstream 32-bit select.

Function
REQ-015 Internal 3-entry halfword queue (count 0..3); head = oldest halfword.
REQ-016 in_ready SHALL be 1 iff count <= 1 and flush = 0, from registered state only (no combinational path from out_ready).
REQ-017 Word transfer (in_valid & in_ready): push low then high halfword; fetch_addr += 4.
REQ-018 If skip flag set at a word transfer: push only high halfword, clear skip.
REQ-019 Head compressed iff head[1:0] != 2'b11.
REQ-020 out_valid SHALL be 1 iff (count >= 1 and head compressed) or count >= 2.
REQ-021 Compressed: out_instr = {16'h0, head}, out_is_c = 1; else out_instr = {entry1, head}, out_is_c = 0.
REQ-022 out_valid = 0 SHALL force out_instr = 0, out_is_c = 0.
REQ-023 Output transfer (out_valid & out_ready): pop 1 (compressed) or 2 halfwords; out_pc += 2 or 4.
REQ-024 Push and pop in the same cycle SHALL both occur; count' = count + pushed - popped, never > 3 or < 0.
REQ-025 32-bit instruction straddling a word boundary: upper half waits in-queue; out_valid stays 0 until next word arrives.
REQ-026 flush: next cycle count = 0, out_pc = {flush_pc[31:1],1'b0}, fetch_addr = {flush_pc[31:2],2'b00}, skip = flush_pc[1]; in-cycle input and output transfers discarded.
REQ-027 flush wins over all simultaneous events; upstream discards its in-flight words on flush.
REQ-028 Address arithmetic 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 permitted.

Reset
REQ-029 rst low: count = 0, out_valid = 0, out_instr = 0, out_is_c = 0, out_pc = {RESET_PC[31:1],1'b0}, fetch_addr = {RESET_PC[31:2],2'b00}, skip = RESET_PC[1], in_ready = 0 while rst low.
REQ-030 Reset mid-operation SHALL discard queued halfwords immediately (asynchronous), no partial output.
REQ-031 First transfer possible on first rising edge after rst deasserts.

Structure
REQ-032 Shared package fetch_pkg: ILEN = 32, HLEN = 16, QDEPTH = 3, RVC_UNCOMPRESSED = 2'b11.
REQ-033 One sub-module hw_queue: 3-entry halfword shift queue with push1/push2/pop1/pop2/clear; control and address counters in fetch_aligner.

Verification
REQ-034 Reset RESET_PC=0; words 32'h0041_0413, 32'h0000_0013 -> out {pc 0, 32'h0041_0413, c=0}, {pc 4, 32'h0000_0013, c=0}.
REQ-035 Word 32'h4505_4501 -> out {pc 0, 32'h0000_4501, c=1}, {pc 2, 32'h0000_4505, c=1}.
REQ-036 Words 32'h0513_4501, 32'h0000_0050 -> {pc 0, 16'h4501, c=1}, then {pc 2, 32'h0050_0513, c=0} only after second word.
REQ-037 flush, flush_pc = 32'h0000_0102; word 32'h4585_4501 at fetch_addr 32'h100 -> single out {pc 32'h102, 32'h0000_4585, c=1}.
REQ-038 out_ready held 0, four words offered -> in_ready drops once count >= 2, no data lost; release -> instructions in order, pc contiguous.
REQ-039 rst asserted with count = 3 mid-stream -> out_valid = 0 immediately, out_pc = RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch aligner and its halfword queue.
package fetch_pkg;
    localparam int ILEN = 32;
    localparam int HLEN = 16;
    localparam int QDEPTH = 3;
    localparam logic [1:0] RVC_UNCOMPRESSED = 2'b11;
endpackage

// File: rtl/hw_queue.sv
// Three-entry halfword shift queue. Entry 0 is the oldest halfword.
// A cycle can both pop and push. The pop is applied first, then the push.
module hw_queue
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push1,
    input  logic            push2,
    input  logic            pop1,
    input  logic            pop2,
    input  logic [HLEN-1:0] push_a,
    input  logic [HLEN-1:0] push_b,
    output logic [HLEN-1:0] head,
    output logic [HLEN-1:0] entry1,
    output logic [1:0]      count
);
    logic [HLEN-1:0] q      [QDEPTH];
    logic [HLEN-1:0] next_q [QDEPTH];
    logic [1:0]      base;
    logic [1:0]      next_count;

    always_comb begin
        next_q = q;
        base   = count;
        if (pop2) begin
            next_q[0] = q[2];
            next_q[1] = '0;
            next_q[2] = '0;
            base      = count - 2'd2;
        end else if (pop1) begin
            next_q[0] = q[1];
            next_q[1] = q[2];
            next_q[2] = '0;
            base      = count - 2'd1;
        end
        // Pushed halfwords land directly behind whatever survived the pop.
        for (int i = 0; i < QDEPTH; i++) begin
            if ((push1 || push2) && i == int'(base))
                next_q[i] = push_a;
            if (push2 && i == int'(base) + 1)
                next_q[i] = push_b;
        end
        next_count = base + (push2 ? 2'd2 : (push1 ? 2'd1 : 2'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else if (clear) begin
            count <= 2'd0;
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else begin
            count <= next_count;
            q     <= next_q;
        end
    end

    assign head   = q[0];
    assign entry1 = q[1];
endmodule

// File: rtl/fetch_aligner.sv
// Splits fetched 32-bit words into 16/32-bit RISC-V instructions.
// It tracks the fetch address, the instruction PC and the mid-word entry skip.
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [31:0]     flush_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    output logic [31:0]     fetch_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [31:0]     out_pc,
    output logic            out_is_c
);
    logic [HLEN-1:0] head;
    logic [HLEN-1:0] entry1;
    logic [1:0]      count;
    logic            skip;
    logic            head_c;
    logic            in_fire;
    logic            out_fire;
    logic            unused_pc_bit;

    assign unused_pc_bit = flush_pc[0];

    assign head_c    = head[1:0] != RVC_UNCOMPRESSED;
    assign out_valid = (count >= 2'd1 && head_c) || count >= 2'd2;
    assign in_ready  = rst && count <= 2'd1 && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !flush;

    always_comb begin
        out_instr = '0;
        out_is_c  = 1'b0;
        if (out_valid) begin
            out_is_c  = head_c;
            out_instr = head_c ? {16'h0000, head} : {entry1, head};
        end
    end

    hw_queue u_queue (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .push1  (in_fire && skip),
        .push2  (in_fire && !skip),
        .pop1   (out_fire && head_c),
        .pop2   (out_fire && !head_c),
        .push_a (skip ? in_data[31:16] : in_data[15:0]),
        .push_b (in_data[31:16]),
        .head   (head),
        .entry1 (entry1),
        .count  (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_pc     <= {RESET_PC[31:1], 1'b0};
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            skip       <= RESET_PC[1];
        end else if (flush) begin
            out_pc     <= {flush_pc[31:1], 1'b0};
            fetch_addr <= {flush_pc[31:2], 2'b00};
            skip       <= flush_pc[1];
        end else begin
            if (in_fire) begin
                fetch_addr <= fetch_addr + 32'd4;
                skip       <= 1'b0;
            end
            if (out_fire)
                out_pc <= out_pc + (head_c ? 32'd2 : 32'd4);
        end
    end
endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: reset, alignment cases, flush, backpressure, wrap.
module tb_fetch_aligner;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] fetch_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_c;

    int checks = 0;
    int errors = 0;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .fetch_addr (fetch_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_is_c   (out_is_c)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b0; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Offers one word and waits (bounded) until it is accepted.
    task automatic push_word(input logic [31:0] w);
        bit done = 0;
        in_valid = 1'b1; in_data = w;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL push_timeout: word %h never accepted, in_ready stayed 0", w);
        end
    endtask

    // Samples the output, then consumes it for one cycle.
    task automatic take(output logic v, output logic [31:0] i, output logic [31:0] pc, output logic c);
        #1;
        v = out_valid; i = out_instr; pc = out_pc; c = out_is_c;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b1; in_data = 32'h0041_0413; out_ready = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", out_instr); end
        checks++; if (out_is_c !== 1'b0) begin errors++; $display("FAIL rst_is_c: got %b want 0", out_is_c); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
        checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL rst_fetch_addr: got %h want 0", fetch_addr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        apply_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_uncompressed();
        logic v, c; logic [31:0] i, pc;
        apply_reset();
        push_word(32'h0041_0413);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0041_0413, 32'h0, 1'b0}) begin
            errors++; $display("FAIL u32_first: got v=%b i=%h pc=%h c=%b want v=1 i=00410413 pc=0 c=0", v, i, pc, c); end
        push_word(32'h0000_0013);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0000_0013, 32'h4, 1'b0}) begin
            errors++; $display("FAIL u32_second: got v=%b i=%h pc=%h c=%b want v=1 i=00000013 pc=4 c=0", v, i, pc, c); end
        checks++; if (fetch_addr !== 32'h8) begin errors++; $display("FAIL u32_fetch_addr: got %h want 8", fetch_addr); end
        checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL u32_out_pc: got %h want 8", out_pc); end
    endtask

    task automatic test_compressed_pair();
        logic v, c; logic [31:0] i, pc;
        apply_reset();
        push_word(32'h4505_4501);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0000_4501, 32'h0, 1'b1}) begin
            errors++; $display("FAIL c16_first: got v=%b i=%h pc=%h c=%b want v=1 i=00004501 pc=0 c=1", v, i, pc, c); end
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0000_4505, 32'h2, 1'b1}) begin
            errors++; $display("FAIL c16_second: got v=%b i=%h pc=%h c=%b want v=1 i=00004505 pc=2 c=1", v, i, pc, c); end
        take(v, i, pc, c);
        checks++; if ({v, i, c} !== {1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL c16_empty: got v=%b i=%h c=%b want v=0 i=0 c=0", v, i, c); end
    endtask

    task automatic test_straddle();
        logic v, c; logic [31:0] i, pc;
        apply_reset();
        push_word(32'h0513_4501);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0000_4501, 32'h0, 1'b1}) begin
            errors++; $display("FAIL strad_c: got v=%b i=%h pc=%h c=%b want v=1 i=00004501 pc=0 c=1", v, i, pc, c); end
        take(v, i, pc, c);
        checks++; if ({v, i} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL strad_wait: got v=%b i=%h want v=0 i=0", v, i); end
        push_word(32'h0000_0050);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0050_0513, 32'h2, 1'b0}) begin
            errors++; $display("FAIL strad_u32: got v=%b i=%h pc=%h c=%b want v=1 i=00500513 pc=2 c=0", v, i, pc, c); end
        checks++; if (out_pc !== 32'h6) begin errors++; $display("FAIL strad_next_pc: got %h want 6", out_pc); end
    endtask

    task automatic test_flush();
        logic v, c; logic [31:0] i, pc;
        apply_reset();
        push_word(32'h0041_0413);
        flush = 1'b1; flush_pc = 32'h0000_0102; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (fetch_addr !== 32'h100) begin errors++; $display("FAIL flush_fetch_addr: got %h want 100", fetch_addr); end
        checks++; if (out_pc !== 32'h102) begin errors++; $display("FAIL flush_out_pc: got %h want 102", out_pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got %b want 0", out_valid); end
        push_word(32'h4585_4501);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0000_4585, 32'h102, 1'b1}) begin
            errors++; $display("FAIL flush_skip: got v=%b i=%h pc=%h c=%b want v=1 i=00004585 pc=102 c=1", v, i, pc, c); end
        take(v, i, pc, c);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL flush_single: got v=%b want 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        logic [31:0] exp_i [6];
        logic [31:0] exp_pc [6];
        logic        exp_c [6];
        int wi = 0;
        int oi = 0;
        words = '{32'h0041_0413, 32'h4505_4501, 32'h0513_4501, 32'h0000_0050};
        exp_i = '{32'h0041_0413, 32'h0000_4501, 32'h0000_4505, 32'h0000_4501, 32'h0050_0513, 32'h0000_0000};
        exp_pc = '{32'd0, 32'd4, 32'd6, 32'd8, 32'd10, 32'd14};
        exp_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int cyc = 0; cyc < 60 && oi < 6; cyc++) begin
            in_valid = wi < 4;
            in_data = (wi < 4) ? words[wi] : 32'h0;
            out_ready = cyc >= 6;
            #1;
            if (cyc == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                checks++; if (fetch_addr !== 32'h4) begin errors++; $display("FAIL bp_fetch_addr: got %h want 4", fetch_addr); end
            end
            if (out_valid && out_ready) begin
                checks++; if ({out_instr, out_pc, out_is_c} !== {exp_i[oi], exp_pc[oi], exp_c[oi]}) begin
                    errors++;
                    $display("FAIL bp_out%0d: got i=%h pc=%h c=%b want i=%h pc=%h c=%b",
                             oi, out_instr, out_pc, out_is_c, exp_i[oi], exp_pc[oi], exp_c[oi]);
                end
                oi++;
            end
            if (in_valid && in_ready) wi++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (oi !== 6) begin errors++; $display("FAIL bp_count: got %0d outputs want 6", oi); end
        checks++; if (fetch_addr !== 32'h10) begin errors++; $display("FAIL bp_final_fetch: got %h want 10", fetch_addr); end
    endtask

    task automatic test_reset_midstream();
        logic v, c; logic [31:0] i, pc;
        apply_reset();
        push_word(32'h0513_4501);
        take(v, i, pc, c);
        push_word(32'h4501_0050);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b want 1", out_valid); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({out_valid, out_instr, out_is_c} !== {1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL mid_rst_out: got v=%b i=%h c=%b want 0/0/0", out_valid, out_instr, out_is_c); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc: got %h want 0", out_pc); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if ({out_valid, out_pc, fetch_addr} !== {1'b0, 32'h0, 32'h0}) begin
            errors++; $display("FAIL mid_release: got v=%b pc=%h fa=%h want 0/0/0", out_valid, out_pc, fetch_addr); end
        push_word(32'h0000_0013);
        take(v, i, pc, c);
        checks++; if ({v, i, pc, c} !== {1'b1, 32'h0000_0013, 32'h0, 1'b0}) begin
            errors++; $display("FAIL mid_restart: got v=%b i=%h pc=%h c=%b want v=1 i=00000013 pc=0 c=0", v, i, pc, c); end
    endtask

    task automatic test_wrap();
        logic v, c; logic [31:0] i, pc;
        apply_reset();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        flush = 1'b0;
        push_word(32'h0000_0013);
        checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL wrap_fetch: got %h want 0", fetch_addr); end
        take(v, i, pc, c);
        checks++; if ({v, i, pc} !== {1'b1, 32'h0000_0013, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_out: got v=%b i=%h pc=%h want v=1 i=00000013 pc=fffffffc", v, i, pc); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", out_pc); end
    endtask

    initial begin
        test_reset();
        test_uncompressed();
        test_compressed_pair();
        test_straddle();
        test_flush();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
